// File: rtl/hpdl1414_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hpdl1414_pkg
// Purpose  : Shared states, character constants and position mapping for the
//            HPDL-1414 character writer.
// Revision : 1.0  initial release
// ============================================================================
package hpdl1414_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_t;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_SINGLE  = 2'd1,
        MODE_REFRESH = 2'd2
    } seq_mode_t;

    localparam logic [6:0] CHR_SPACE = 7'h20;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_BS    = 8'h08;

    typedef struct packed {
        logic [1:0] dev;
        logic [1:0] addr;
    } hpdl_loc_t;

    // Position 0 is the leftmost digit, which each device calls address 3.
    function automatic hpdl_loc_t pos_to_loc(input logic [3:0] pos);
        hpdl_loc_t loc;
        loc.dev  = pos[3:2];
        loc.addr = 2'd3 - pos[1:0];
        return loc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpdl1414_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : hpdl1414_bus_timer
// Purpose  : One-shot SETUP/STROBE/HOLD write cycle on the shared HPDL bus.
// Revision : 1.0  initial release
// ============================================================================
module hpdl1414_bus_timer
    import hpdl1414_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_WR    = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] dev,
    input  logic [1:0] addr,
    input  logic [6:0] data,
    output logic       done,
    output logic [6:0] hpdl_d,
    output logic [1:0] hpdl_a,
    output logic [3:0] hpdl_wr_n
);

    // Phase counter sized for timing parameters up to 256 cycles.
    localparam int CW = 8;

    bus_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          load;
    logic [1:0]    dev_q;

    // start is honoured in IDLE or on the final HOLD cycle, so refresh slots
    // chain back-to-back without an idle gap.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        done     = 1'b0;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = ST_SETUP;
                    load     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == CW'(T_SETUP - 1)) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = '0;
                end
            end
            ST_STROBE: begin
                if (cnt == CW'(T_WR - 1)) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt == CW'(T_HOLD - 1)) begin
                    done   = 1'b1;
                    cnt_nx = '0;
                    if (start) begin
                        state_nx = ST_SETUP;
                        load     = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Strobe is registered from the next state so WR is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dev_q     <= '0;
            hpdl_d    <= CHR_SPACE;
            hpdl_a    <= '0;
            hpdl_wr_n <= 4'hF;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                dev_q  <= dev;
                hpdl_d <= data;
                hpdl_a <= addr;
            end
            hpdl_wr_n <= (state_nx == ST_STROBE) ? ~(4'b0001 << dev_q) : 4'hF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hpdl1414_char_writer.sv
`default_nettype none
// ============================================================================
// Module   : hpdl1414_char_writer
// Purpose  : UART byte sink driving four HPDL-1414 displays (16 characters).
//            Optional HPDL_SCROLL_EN: scroll left instead of wrapping at 15.
// Revision : 1.0  initial release
// ============================================================================
module hpdl1414_char_writer
    import hpdl1414_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int T_WR     = 4,
    parameter int T_HOLD   = 2,
    parameter int NUM_DISP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [6:0]          hpdl_d,
    output logic [1:0]          hpdl_a,
    output logic [NUM_DISP-1:0] hpdl_wr_n,
    output logic                busy
);

    seq_mode_t  mode, mode_nx;
    logic [3:0] pos, pos_nx;
    logic       launch, launch_nx;
    logic [3:0] cursor;
    logic [6:0] buffer [16];
`ifdef HPDL_SCROLL_EN
    logic       armed;
`endif

    logic       accept, is_print, req_single, req_refresh;
    logic [6:0] ch;
    logic       start, done;
    logic [3:0] start_pos;
    hpdl_loc_t  start_loc;

    assign rx_ready = (mode == MODE_IDLE);
    assign busy     = ~rx_ready;
    assign accept   = rx_valid & rx_ready;

    // 0x20..0x7F are printable; 0x60..0x7F fold to upper case by clearing bit 5.
    assign is_print = ~rx_data[7] & (rx_data[6:5] != 2'b00);
    assign ch       = (rx_data[6:5] == 2'b11) ? {2'b10, rx_data[4:0]} : rx_data[6:0];

`ifdef HPDL_SCROLL_EN
    assign req_refresh = (rx_data == CHR_FF) | (is_print & armed);
    assign req_single  = is_print & ~armed;
`else
    assign req_refresh = (rx_data == CHR_FF);
    assign req_single  = is_print;
`endif

    // During a refresh the next slot is launched on the done cycle of the current one.
    assign start     = launch | ((mode == MODE_REFRESH) && done && (pos != 4'd15));
    assign start_pos = launch ? pos : pos + 4'd1;
    assign start_loc = pos_to_loc(start_pos);

    always_comb begin
        mode_nx   = mode;
        pos_nx    = pos;
        launch_nx = 1'b0;
        case (mode)
            MODE_IDLE: begin
                if (accept && req_refresh) begin
                    mode_nx   = MODE_REFRESH;
                    pos_nx    = 4'd0;
                    launch_nx = 1'b1;
                end else if (accept && req_single) begin
                    mode_nx   = MODE_SINGLE;
                    pos_nx    = cursor;
                    launch_nx = 1'b1;
                end
            end
            MODE_SINGLE: begin
                if (done) mode_nx = MODE_IDLE;
            end
            MODE_REFRESH: begin
                if (done) begin
                    if (pos == 4'd15) mode_nx = MODE_IDLE;
                    else              pos_nx  = pos + 4'd1;
                end
            end
            default: mode_nx = MODE_IDLE;
        endcase
    end

    // Reset leaves a refresh pending so the first clock starts painting spaces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_REFRESH;
            pos    <= 4'd0;
            launch <= 1'b1;
        end else begin
            mode   <= mode_nx;
            pos    <= pos_nx;
            launch <= launch_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor <= 4'd0;
            for (int i = 0; i < 16; i++) buffer[i] <= CHR_SPACE;
`ifdef HPDL_SCROLL_EN
            armed  <= 1'b0;
`endif
        end else if (accept) begin
            if (is_print) begin
`ifdef HPDL_SCROLL_EN
                if (armed) begin
                    for (int i = 0; i < 15; i++) buffer[i] <= buffer[i+1];
                    buffer[15] <= ch;
                end else begin
                    buffer[cursor] <= ch;
                    if (cursor == 4'd15) armed  <= 1'b1;
                    else                 cursor <= cursor + 4'd1;
                end
`else
                buffer[cursor] <= ch;
                cursor         <= cursor + 4'd1;
`endif
            end else if (rx_data == CHR_CR) begin
                cursor <= 4'd0;
`ifdef HPDL_SCROLL_EN
                armed  <= 1'b0;
`endif
            end else if (rx_data == CHR_FF) begin
                cursor <= 4'd0;
                for (int i = 0; i < 16; i++) buffer[i] <= CHR_SPACE;
`ifdef HPDL_SCROLL_EN
                armed  <= 1'b0;
`endif
            end else if (rx_data == CHR_BS) begin
                if (cursor != 4'd0) cursor <= cursor - 4'd1;
`ifdef HPDL_SCROLL_EN
                armed  <= 1'b0;
`endif
            end
        end
    end

    hpdl1414_bus_timer #(
        .T_SETUP (T_SETUP),
        .T_WR    (T_WR),
        .T_HOLD  (T_HOLD)
    ) u_bus_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dev       (start_loc.dev),
        .addr      (start_loc.addr),
        .data      (buffer[start_pos]),
        .done      (done),
        .hpdl_d    (hpdl_d),
        .hpdl_a    (hpdl_a),
        .hpdl_wr_n (hpdl_wr_n)
    );

endmodule
`default_nettype wire

// File: tb/tb_hpdl1414_char_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpdl1414_char_writer
// Purpose  : Directed self-checking bench for hpdl1414_char_writer.
// Revision : 1.0  initial release
// ============================================================================
module tb_hpdl1414_char_writer;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready, busy;
    logic [6:0] hpdl_d;
    logic [1:0] hpdl_a;
    logic [3:0] hpdl_wr_n;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int accept_cyc = 0;

    typedef struct {
        logic [1:0] dev;
        logic [1:0] a;
        logic [6:0] d;
        int         fall;
    } pulse_t;
    pulse_t pq[$];
    int     widths[$];

    hpdl1414_char_writer #(
        .T_SETUP  (2),
        .T_WR     (4),
        .T_HOLD   (2),
        .NUM_DISP (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .hpdl_d    (hpdl_d),
        .hpdl_a    (hpdl_a),
        .hpdl_wr_n (hpdl_wr_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] dev_of(input logic [3:0] wn);
        case (~wn)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Bus monitor: one-hot strobe, stable bus during strobe, pulse log.
    initial begin
        logic [3:0] prev;
        int         w;
        prev = 4'hF;
        w    = 0;
        forever begin
            @(negedge clk);
            if (hpdl_wr_n != 4'hF) begin
                check("wr_onehot", 32'($countones(~hpdl_wr_n)), 32'd1);
                if (prev == 4'hF) begin
                    pulse_t p;
                    p.dev  = dev_of(hpdl_wr_n);
                    p.a    = hpdl_a;
                    p.d    = hpdl_d;
                    p.fall = cyc;
                    pq.push_back(p);
                    w = 0;
                end else begin
                    check("bus_stable", 32'({hpdl_a, hpdl_d}),
                          32'({pq[pq.size()-1].a, pq[pq.size()-1].d}));
                end
                w++;
            end else if (prev != 4'hF) begin
                widths.push_back(w);
            end
            prev = hpdl_wr_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n >= 1000), 32'd0);
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        rx_valid   = 1'b0;
    endtask

    task automatic wait_ready(input int ref_cyc, output int delay);
        int n;
        n = 0;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n >= 2000), 32'd0);
        delay = cyc - ref_cyc;
    endtask

    task automatic check_pulse(input int idx, input logic [1:0] dev, input logic [1:0] a,
                               input logic [6:0] d, input string tag);
        if (idx >= pq.size()) begin
            check({tag, "_missing"}, 32'(pq.size()), 32'(idx + 1));
        end else begin
            check({tag, "_dev_a_d"}, 32'({pq[idx].dev, pq[idx].a, pq[idx].d}), 32'({dev, a, d}));
            if (idx < widths.size()) check({tag, "_width"}, 32'(widths[idx]), 32'd4);
            else                     check({tag, "_width_missing"}, 32'(widths.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_refresh(input int base, input logic [6:0] fill, input logic [6:0] last);
        logic [3:0] p;
        for (int i = 0; i < 16; i++) begin
            p = 4'(i);
            check_pulse(base + i, p[3:2], 2'd3 - p[1:0], (i == 15) ? last : fill, "refresh");
        end
    endtask

    function automatic int fall_of(input int idx);
        return (idx < pq.size()) ? pq[idx].fall : -1000;
    endfunction

    initial begin
        int d, c0, base, n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wr_n", 32'(hpdl_wr_n), 32'h0F);
        check("rst_d", 32'(hpdl_d), 32'h20);
        check("rst_a", 32'(hpdl_a), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Post-reset refresh
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        wait_ready(c0, d);
        check("boot_refresh_cycles", 32'(d), 32'd128);
        check("boot_refresh_count", 32'(pq.size()), 32'd16);
        check_refresh(0, 7'h20, 7'h20);
        check("boot_first_fall", 32'(fall_of(0) - c0), 32'd2);

        // 'H' then 'i' (folded to 'I')
        base = pq.size();
        send(8'h48);
        check("h_busy", 32'(busy), 32'd1);
        wait_ready(accept_cyc, d);
        check("h_ready_lat", 32'(d), 32'd9);
        check("h_wr_lat", 32'(fall_of(base) - accept_cyc), 32'd3);
        check_pulse(base, 2'd0, 2'd3, 7'h48, "h");
        send(8'h69);
        wait_ready(accept_cyc, d);
        check("i_wr_lat", 32'(fall_of(base + 1) - accept_cyc), 32'd3);
        check_pulse(base + 1, 2'd0, 2'd2, 7'h49, "i");

        // CR, 16 x 'A', then 'B'
        send(8'h0D);
        wait_ready(accept_cyc, d);
        base = pq.size();
        for (int i = 0; i < 16; i++) begin
            send(8'h41);
            wait_ready(accept_cyc, d);
        end
        send(8'h42);
        wait_ready(accept_cyc, d);
        check_pulse(base + 15, 2'd3, 2'd0, 7'h41, "a_pos15");
`ifdef HPDL_SCROLL_EN
        check("scroll_count", 32'(pq.size() - base), 32'd32);
        check_refresh(base + 16, 7'h41, 7'h42);
`else
        check("wrap_count", 32'(pq.size() - base), 32'd17);
        check_pulse(base + 16, 2'd0, 2'd3, 7'h42, "wrap_b");
`endif

        // CR, 'X', CR, 'Y'
        send(8'h0D);
        wait_ready(accept_cyc, d);
        base = pq.size();
        send(8'h58);
        wait_ready(accept_cyc, d);
        send(8'h0D);
        wait_ready(accept_cyc, d);
        check("cr_ready_lat", 32'(d), 32'd0);
        repeat (10) @(negedge clk);
        check("cr_no_wr", 32'(pq.size() - base), 32'd1);
        send(8'h59);
        wait_ready(accept_cyc, d);
        check_pulse(base, 2'd0, 2'd3, 7'h58, "x");
        check_pulse(base + 1, 2'd0, 2'd3, 7'h59, "y");

        // 'Q', FF, BS at cursor 0, 'Z', BS, 0x7F
        send(8'h51);
        wait_ready(accept_cyc, d);
        check_pulse(pq.size() - 1, 2'd0, 2'd2, 7'h51, "q");
        base = pq.size();
        send(8'h0C);
        wait_ready(accept_cyc, d);
        check("ff_ready_lat", 32'(d), 32'd129);
        check("ff_count", 32'(pq.size() - base), 32'd16);
        check_refresh(base, 7'h20, 7'h20);
        base = pq.size();
        send(8'h08);
        wait_ready(accept_cyc, d);
        check("bs_ready_lat", 32'(d), 32'd0);
        send(8'h5A);
        wait_ready(accept_cyc, d);
        check_pulse(base, 2'd0, 2'd3, 7'h5A, "z");
        send(8'h08);
        wait_ready(accept_cyc, d);
        send(8'h7F);
        wait_ready(accept_cyc, d);
        check_pulse(base + 1, 2'd0, 2'd3, 7'h5F, "del_fold");

        // Ignored codes
        base = pq.size();
        send(8'h07);
        wait_ready(accept_cyc, d);
        check("bel_ready_lat", 32'(d), 32'd0);
        send(8'h95);
        wait_ready(accept_cyc, d);
        check("hi_ready_lat", 32'(d), 32'd0);
        repeat (12) @(negedge clk);
        check("ignored_no_wr", 32'(pq.size() - base), 32'd0);

        // Reset during STROBE
        send(8'h4B);
        n = 0;
        while (hpdl_wr_n == 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", 32'(n >= 100), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_wr_n", 32'(hpdl_wr_n), 32'h0F);
        check("midrst_ready", 32'(rx_ready), 32'd0);
        repeat (2) @(negedge clk);
        pq.delete();
        widths.delete();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        wait_ready(c0, d);
        check("rerefresh_cycles", 32'(d), 32'd128);
        check("rerefresh_count", 32'(pq.size()), 32'd16);
        check_refresh(0, 7'h20, 7'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
